// File: rtl/elapsed_timer_ascii_if.sv
// Control and display bundle for elapsed_timer_ascii: level commands in, ASCII MM:SS,
// pulse count and motor pulse out. No handshake; every signal is sampled or valid each cycle.
interface elapsed_timer_ascii_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       running;
  logic       done;
  logic [7:0] min_tens;
  logic [7:0] min_ones;
  logic [7:0] colon;
  logic [7:0] sec_tens;
  logic [7:0] sec_ones;
  logic [7:0] frac_tens;
  logic [7:0] frac_ones;
  logic       motor_signal;

  modport master (
    output start, stop, clear,
    input  running, done, min_tens, min_ones, colon, sec_tens, sec_ones,
           frac_tens, frac_ones, motor_signal
  );

  modport slave (
    input  start, stop, clear,
    output running, done, min_tens, min_ones, colon, sec_tens, sec_ones,
           frac_tens, frac_ones, motor_signal
  );
endinterface

// File: rtl/elapsed_timer_ascii.sv
// MM:SS elapsed timer with periodic fixed-width motor pulse; digits update on the tick edge,
// commands act on the next edge, no backpressure (level inputs, registered outputs).
module elapsed_timer_ascii #(
  parameter int CLK_HZ         = 50000000,
  parameter int PULSE_PERIOD_S = 30,
  parameter int PULSE_WIDTH    = 1,
  parameter int WRAP           = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  elapsed_timer_ascii_if.slave  bus
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]    PER_MAX   = 8'(PULSE_PERIOD_S - 1);
  localparam logic [15:0]   WID_LOAD  = 16'(PULSE_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [3:0]    s1, s10, m1, m10;
  logic [3:0]    p1, p10;
  logic [7:0]    per;
  logic [15:0]   wid;
  logic          tick;
  logic          reach_max;
  logic          trig;

  assign tick      = (state == RUN) && (presc == PRESC_MAX);
  assign reach_max = (m10 == 4'd9) && (m1 == 4'd9) && (s10 == 4'd5) && (s1 == 4'd8);
  assign trig      = tick && (per == PER_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop outranks start, so stop+start together never enters RUN
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        RUN: begin
          if (tick && reach_max && (WRAP == 0)) state_nxt = DONE;
          else if (bus.stop)                    state_nxt = PAUSED;
        end
        IDLE, PAUSED: begin
          if (!bus.stop && bus.start) state_nxt = RUN;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      presc <= '0;
      s1    <= '0;
      s10   <= '0;
      m1    <= '0;
      m10   <= '0;
      p1    <= '0;
      p10   <= '0;
      per   <= '0;
      wid   <= '0;
    end else begin
      if (state == IDLE || tick) presc <= '0;
      else if (state == RUN)     presc <= presc + PW'(1);

      if (tick) begin
        if (s1 != 4'd9) s1 <= s1 + 4'd1;
        else begin
          s1 <= 4'd0;
          if (s10 != 4'd5) s10 <= s10 + 4'd1;
          else begin
            s10 <= 4'd0;
            if (m1 != 4'd9) m1 <= m1 + 4'd1;
            else begin
              m1  <= 4'd0;
              m10 <= (m10 == 4'd9) ? 4'd0 : m10 + 4'd1;
            end
          end
        end
        per <= trig ? 8'd0 : per + 8'd1;
      end

      // a new trigger restarts the pulse rather than stacking on it
      if (trig)             wid <= WID_LOAD;
      else if (wid != '0)   wid <= wid - 16'd1;

      if (trig) begin
        if (p1 != 4'd9) p1 <= p1 + 4'd1;
        else begin
          p1  <= 4'd0;
          p10 <= (p10 == 4'd9) ? 4'd0 : p10 + 4'd1;
        end
      end
    end
  end

  assign bus.running      = (state == RUN);
  assign bus.done         = (state == DONE);
  assign bus.min_tens     = {4'h3, m10};
  assign bus.min_ones     = {4'h3, m1};
  assign bus.colon        = 8'h3A;
  assign bus.sec_tens     = {4'h3, s10};
  assign bus.sec_ones     = {4'h3, s1};
  assign bus.frac_tens    = {4'h3, p10};
  assign bus.frac_ones    = {4'h3, p1};
  assign bus.motor_signal = (wid != '0);

endmodule

// File: tb/tb_elapsed_timer_ascii.sv
// Two timer instances (wrap / saturate) driven by the same commands and checked each cycle
// against an integer-seconds model, plus literal checkpoints from hand-worked timelines.
module tb_elapsed_timer_ascii;
  localparam int HZ = 4;
  localparam int PER0 = 3, WID0 = 2, WRAP0 = 1;
  localparam int PER1 = 1, WID1 = 5, WRAP1 = 0;

  logic clk = 1'b0;
  logic rst, start, stop, clear;
  bit   cmp_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  elapsed_timer_ascii_if bus0 ();
  elapsed_timer_ascii_if bus1 ();

  assign bus0.start = start;
  assign bus0.stop  = stop;
  assign bus0.clear = clear;
  assign bus1.start = start;
  assign bus1.stop  = stop;
  assign bus1.clear = clear;

  elapsed_timer_ascii #(.CLK_HZ(HZ), .PULSE_PERIOD_S(PER0), .PULSE_WIDTH(WID0), .WRAP(WRAP0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  elapsed_timer_ascii #(.CLK_HZ(HZ), .PULSE_PERIOD_S(PER1), .PULSE_WIDTH(WID1), .WRAP(WRAP1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // model: 0 idle, 1 run, 2 paused, 3 done; secs is elapsed seconds mod 6000
  int per_cfg[2]  = '{PER0, PER1};
  int wid_cfg[2]  = '{WID0, WID1};
  int wrap_cfg[2] = '{WRAP0, WRAP1};
  int m_st[2], m_presc[2], m_secs[2], m_ticks[2], m_pulses[2], m_wid[2];

  task automatic step(input int i);
    bit tk, trig;
    if (rst || clear) begin
      m_st[i] = 0; m_presc[i] = 0; m_secs[i] = 0;
      m_ticks[i] = 0; m_pulses[i] = 0; m_wid[i] = 0;
    end else begin
      tk   = (m_st[i] == 1) && (m_presc[i] == HZ - 1);
      trig = 1'b0;
      if (tk) begin
        m_ticks[i]++;
        m_secs[i] = (m_secs[i] + 1) % 6000;
        trig = (m_ticks[i] % per_cfg[i]) == 0;
        if (trig) m_pulses[i] = (m_pulses[i] + 1) % 100;
      end
      if (trig)              m_wid[i] = wid_cfg[i];
      else if (m_wid[i] > 0) m_wid[i] = m_wid[i] - 1;
      if (m_st[i] == 0)      m_presc[i] = 0;
      else if (m_st[i] == 1) m_presc[i] = tk ? 0 : m_presc[i] + 1;
      case (m_st[i])
        1: begin
          if (tk && wrap_cfg[i] == 0 && m_secs[i] == 5999) m_st[i] = 3;
          else if (stop) m_st[i] = 2;
        end
        0, 2: if (!stop && start) m_st[i] = 1;
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
  end

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, i, $time, act, exp);
    end
  endtask

  task automatic cmp(input int i, input logic run, input logic dn, input logic mot,
                     input logic [7:0] mt, input logic [7:0] mo, input logic [7:0] co,
                     input logic [7:0] st, input logic [7:0] so,
                     input logic [7:0] ft, input logic [7:0] fo);
    int mm, ss;
    mm = m_secs[i] / 60;
    ss = m_secs[i] % 60;
    chk("running",   i, 8'(run), 8'(m_st[i] == 1));
    chk("done",      i, 8'(dn),  8'(m_st[i] == 3));
    chk("motor",     i, 8'(mot), 8'(m_wid[i] != 0));
    chk("min_tens",  i, mt, 8'(48 + mm / 10));
    chk("min_ones",  i, mo, 8'(48 + mm % 10));
    chk("colon",     i, co, 8'h3A);
    chk("sec_tens",  i, st, 8'(48 + ss / 10));
    chk("sec_ones",  i, so, 8'(48 + ss % 10));
    chk("frac_tens", i, ft, 8'(48 + m_pulses[i] / 10));
    chk("frac_ones", i, fo, 8'(48 + m_pulses[i] % 10));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, bus0.running, bus0.done, bus0.motor_signal, bus0.min_tens, bus0.min_ones,
          bus0.colon, bus0.sec_tens, bus0.sec_ones, bus0.frac_tens, bus0.frac_ones);
      cmp(1, bus1.running, bus1.done, bus1.motor_signal, bus1.min_tens, bus1.min_ones,
          bus1.colon, bus1.sec_tens, bus1.sec_ones, bus1.frac_tens, bus1.frac_ones);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves us at the negedge just after the edge that sampled start
  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_min_tens", 0, bus0.min_tens, 8'h30);
    chk("rst_colon",    0, bus0.colon, 8'h3A);
    chk("rst_running",  1, 8'(bus1.running), 8'h00);
    chk("rst_motor",    0, 8'(bus0.motor_signal), 8'h00);
    rst = 1'b0;

    // 13 ticks: pulses at 00:03/06/09/12
    pulse_start();
    cyc(12);
    chk("t1_sec_03",     0, bus0.sec_ones, 8'h33);
    chk("t1_motor_rise", 0, 8'(bus0.motor_signal), 8'h01);
    cyc(1);
    chk("t1_motor_hold", 0, 8'(bus0.motor_signal), 8'h01);
    cyc(1);
    chk("t1_motor_fall", 0, 8'(bus0.motor_signal), 8'h00);
    cyc(38);
    chk("t1_sec_tens",   0, bus0.sec_tens, 8'h31);
    chk("t1_sec_ones",   0, bus0.sec_ones, 8'h33);
    chk("t1_frac_tens",  0, bus0.frac_tens, 8'h30);
    chk("t1_frac_ones",  0, bus0.frac_ones, 8'h34);
    chk("t1_frac1_ones", 1, bus1.frac_ones, 8'h33);

    // pause with two prescaler cycles banked
    pulse_clear();
    pulse_start();
    cyc(4);
    chk("t2_sec_01", 0, bus0.sec_ones, 8'h31);
    cyc(1);
    stop = 1'b1; cyc(20);
    chk("t2_paused_sec",  0, bus0.sec_ones, 8'h31);
    chk("t2_paused_run",  0, 8'(bus0.running), 8'h00);
    stop = 1'b0;
    pulse_start();
    cyc(1);
    chk("t2_resume_r1", 0, bus0.sec_ones, 8'h31);
    cyc(1);
    chk("t2_resume_r2", 0, bus0.sec_ones, 8'h32);

    // 99:59 wrap vs saturate
    pulse_clear();
    pulse_start();
    cyc(4 * 5999);
    chk("t3_max_mt",   0, bus0.min_tens, 8'h39);
    chk("t3_max_so",   0, bus0.sec_ones, 8'h39);
    chk("t4_done",     1, 8'(bus1.done), 8'h01);
    chk("t4_run",      1, 8'(bus1.running), 8'h00);
    chk("t4_max_st",   1, bus1.sec_tens, 8'h35);
    cyc(4);
    chk("t3_wrap_mt",  0, bus0.min_tens, 8'h30);
    chk("t3_wrap_so",  0, bus0.sec_ones, 8'h30);
    chk("t3_wrap_run", 0, 8'(bus0.running), 8'h01);
    chk("t4_hold_mt",  1, bus1.min_tens, 8'h39);
    cyc(12);
    chk("t4_hold_so",  1, bus1.sec_ones, 8'h39);
    pulse_start();
    cyc(1);
    chk("t4_start_ign", 1, 8'(bus1.done), 8'h01);
    pulse_clear();
    chk("t4_clr_done", 1, 8'(bus1.done), 8'h00);
    chk("t4_clr_mt",   1, bus1.min_tens, 8'h30);

    // clear+start together mid-pulse
    pulse_start();
    cyc(6);
    chk("t5_mid_pulse", 1, 8'(bus1.motor_signal), 8'h01);
    clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
    chk("t5_run",   1, 8'(bus1.running), 8'h00);
    chk("t5_motor", 1, 8'(bus1.motor_signal), 8'h00);
    chk("t5_so",    1, bus1.sec_ones, 8'h30);
    chk("t5_fo",    1, bus1.frac_ones, 8'h30);
    pulse_start();
    chk("t5_restart", 1, 8'(bus1.running), 8'h01);

    // reset at 12:34
    pulse_clear();
    pulse_start();
    cyc(4 * 754);
    chk("t6_mt", 0, bus0.min_tens, 8'h31);
    chk("t6_mo", 0, bus0.min_ones, 8'h32);
    chk("t6_st", 0, bus0.sec_tens, 8'h33);
    chk("t6_so", 0, bus0.sec_ones, 8'h34);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("t6_rst_run", 0, 8'(bus0.running), 8'h00);
    chk("t6_rst_mo",  0, bus0.min_ones, 8'h30);
    chk("t6_rst_so",  0, bus0.sec_ones, 8'h30);
    cyc(12);
    chk("t6_no_tick", 0, bus0.sec_ones, 8'h30);

    // random command soak
    for (int k = 0; k < 4000; k++) begin
      start = ($urandom_range(0, 99) < 8);
      stop  = ($urandom_range(0, 99) < 4);
      clear = ($urandom_range(0, 199) < 2);
      rst   = ($urandom_range(0, 999) < 2);
      cyc(1);
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
